// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw pin source and the input debouncer.
// The glitch_cnt_o signal exists only when INPUT_DEBOUNCER_GLITCH_CNT_EN is defined.
interface input_debouncer_if #(
  parameter int GLITCH_W = 8
);

  logic raw_i;
  logic debounced_o;
  logic busy_o;

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_cnt_o;

  modport master (
    output raw_i,
    input  debounced_o,
    input  busy_o,
    input  glitch_cnt_o
  );

  modport slave (
    input  raw_i,
    output debounced_o,
    output busy_o,
    output glitch_cnt_o
  );
`else
  // GLITCH_W only sizes the optional counter; keep it referenced in this build.
  logic unused_glitch_w;
  assign unused_glitch_w = ^GLITCH_W;

  modport master (
    output raw_i,
    input  debounced_o,
    input  busy_o
  );

  modport slave (
    input  raw_i,
    output debounced_o,
    output busy_o
  );
`endif

endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability-counting FSM that commits a new level
// only after DEBOUNCE_CYCLES agreeing samples. Optional glitch counter: INPUT_DEBOUNCER_GLITCH_CNT_EN.
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   GLITCH_W        = 8
) (
  input logic             clk,
  input logic             reset,
  input_debouncer_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               deb_q, deb_d;
  logic               abort;

  always_comb begin
    sync1_d = bus.raw_i;
    sync2_d = sync1_q;
  end

  // Only the synchronized sample sync2_q is compared against the committed level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    abort   = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync2_q != deb_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            deb_d = ~deb_q;
          end else begin
            state_d = PENDING;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PENDING: begin
        if (sync2_q == deb_q) begin
          state_d = STABLE;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d   = ~deb_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      deb_q   <= RESET_LEVEL;
      state_q <= STABLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.debounced_o = deb_q;
  assign bus.busy_o      = (state_q == PENDING);

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  // Saturating count of aborted qualifications; only reset clears it.
  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign bus.glitch_cnt_o = glitch_q;
`else
  logic unused_glitch;
  assign unused_glitch = ^{abort, GLITCH_W};
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer: three instances cover the default
// configuration, a 2-bit glitch counter (saturation) and DEBOUNCE_CYCLES=1.
module tb_input_debouncer;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  input_debouncer_if #(.GLITCH_W(8)) bus_a ();
  input_debouncer_if #(.GLITCH_W(2)) bus_b ();
  input_debouncer_if #(.GLITCH_W(8)) bus_c ();

  input_debouncer #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0), .GLITCH_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0), .GLITCH_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0), .GLITCH_W(8)) dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_c)
  );

  // Edge-detector stand-in: counts committed rises and falls of instance A.
  logic mon_en = 1'b0;
  logic prev_a = 1'b0;
  int   rises_a = 0;
  int   falls_a = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_a.debounced_o && !prev_a) rises_a <= rises_a + 1;
      if (!bus_a.debounced_o && prev_a) falls_a <= falls_a + 1;
    end
    prev_a <= bus_a.debounced_o;
  end

  task automatic applyStimulus(input logic rst_n, input logic ra, input logic rb,
                               input logic rc, input int n);
    reset       = rst_n;
    bus_a.raw_i = ra;
    bus_b.raw_i = rb;
    bus_c.raw_i = rc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [6:0] bounce_pat;

    // Reset held 3 edges with raw high; sync flops must still load RESET_LEVEL.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("reset_deb_a",  {7'b0, bus_a.debounced_o}, 8'h00);
    checkOutput("reset_busy_a", {7'b0, bus_a.busy_o},      8'h00);
    checkOutput("reset_deb_c",  {7'b0, bus_c.debounced_o}, 8'h00);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    checkOutput("reset_glitch_a", bus_a.glitch_cnt_o, 8'h00);
    checkOutput("reset_glitch_b", {6'b0, bus_b.glitch_cnt_o}, 8'h00);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("idle_deb_a",  {7'b0, bus_a.debounced_o}, 8'h00);
    checkOutput("idle_busy_a", {7'b0, bus_a.busy_o},      8'h00);
    mon_en = 1'b1;

    // Clean rise: edges 0,1 synchronize, 2..4 qualify, 5 commits.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2);
    checkOutput("rise_busy_e1", {7'b0, bus_a.busy_o}, 8'h00);
    for (int e = 2; e <= 4; e++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("rise_busy_pend", {7'b0, bus_a.busy_o},      8'h01);
      checkOutput("rise_deb_pend",  {7'b0, bus_a.debounced_o}, 8'h00);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("rise_deb_e5",  {7'b0, bus_a.debounced_o}, 8'h01);
    checkOutput("rise_busy_e5", {7'b0, bus_a.busy_o},      8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("rise_hold", {7'b0, bus_a.debounced_o}, 8'h01);

    // Clean fall with the same latency.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5);
    checkOutput("fall_deb_e4",  {7'b0, bus_a.debounced_o}, 8'h01);
    checkOutput("fall_busy_e4", {7'b0, bus_a.busy_o},      8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("fall_deb_e5",  {7'b0, bus_a.debounced_o}, 8'h00);
    checkOutput("fall_busy_e5", {7'b0, bus_a.busy_o},      8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("edge_rises", rises_a[7:0], 8'h01);
    checkOutput("edge_falls", falls_a[7:0], 8'h01);

    // Bounce: 1,1,0,1,1,1 then 0 -- two aborted qualifications, no commit.
    bounce_pat = 7'b0111011;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, bounce_pat[i], 1'b0, 1'b0, 1);
      checkOutput("bounce_deb", {7'b0, bus_a.debounced_o}, 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("bounce_settle_deb", {7'b0, bus_a.debounced_o}, 8'h00);
    end
    checkOutput("bounce_busy", {7'b0, bus_a.busy_o}, 8'h00);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    checkOutput("bounce_glitch_a", bus_a.glitch_cnt_o, 8'h02);
`endif

    // Five single-sample pulses on B: the 2-bit counter must stop at 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4);
    checkOutput("sat_deb_b",  {7'b0, bus_b.debounced_o}, 8'h00);
    checkOutput("sat_busy_b", {7'b0, bus_b.busy_o},      8'h00);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    checkOutput("sat_glitch_b",     {6'b0, bus_b.glitch_cnt_o}, 8'h03);
    checkOutput("sat_glitch_a_hold", bus_a.glitch_cnt_o,       8'h02);
`endif

    // DEBOUNCE_CYCLES=1: level follows after edge 2, never busy.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2);
    checkOutput("dc1_rise_e1", {7'b0, bus_c.debounced_o}, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("dc1_rise_e2", {7'b0, bus_c.debounced_o}, 8'h01);
    checkOutput("dc1_busy",    {7'b0, bus_c.busy_o},      8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("dc1_fall_e1", {7'b0, bus_c.debounced_o}, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("dc1_fall_e2", {7'b0, bus_c.debounced_o}, 8'h00);

    // Reset while A is qualifying a rise discards it without counting a glitch.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("midq_busy_before", {7'b0, bus_a.busy_o}, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("midq_deb",  {7'b0, bus_a.debounced_o}, 8'h00);
    checkOutput("midq_busy", {7'b0, bus_a.busy_o},      8'h00);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    checkOutput("midq_glitch_a", bus_a.glitch_cnt_o,        8'h00);
    checkOutput("midq_glitch_b", {6'b0, bus_b.glitch_cnt_o}, 8'h00);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6);
    checkOutput("post_rst_deb",  {7'b0, bus_a.debounced_o}, 8'h00);
    checkOutput("post_rst_busy", {7'b0, bus_a.busy_o},      8'h00);
    checkOutput("post_rst_rises", rises_a[7:0], 8'h01);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    checkOutput("post_rst_glitch_a", bus_a.glitch_cnt_o, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions a raw, asynchronous, possibly bouncing serial input into a clean single-clock-domain level.
- Sits directly upstream of the rising/falling edge detector; its debounced_o drives that stage's serial input a_i.
- Consists of a 2-flop synchronizer, then a stability-counting state machine that commits a new level only after it has held for a programmable number of cycles.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples at the new level required before debounced_o changes; legal range >= 1.
- RESET_LEVEL, 1'b0, level loaded into the synchronizer flops and debounced_o on reset.
- GLITCH_W, 8, width of the glitch counter. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset: sampled on posedge clk, asserted when 0.
- raw_i  input  1  raw asynchronous input (switch/pin); may bounce.
- debounced_o  output  1  clean, registered level; feeds the edge detector.
- busy_o  output  1  high while a candidate level change is being qualified (PENDING state).
- glitch_cnt_o  output  GLITCH_W  saturating count of rejected bounces. Present only with INPUT_DEBOUNCER_GLITCH_CNT_EN.

Behaviour:
- Reset (reset==0 at posedge):
  - sync1, sync2 and debounced_o load RESET_LEVEL.
  - state <= STABLE; counter <= 0; busy_o = 0; glitch_cnt_o <= 0.
  - Reset overrides everything, including mid-qualification: the pending change is discarded and not counted as a glitch.
- Synchronizer: sync1 <= raw_i; sync2 <= sync1. Only sync2 ("s") feeds the FSM; raw_i is never used directly.
- Counter: CNT_W = $clog2(DEBOUNCE_CYCLES+1) bits, unsigned, never wraps.
- State STABLE:
  - if s == debounced_o: stay; counter held at 0.
  - if s != debounced_o and DEBOUNCE_CYCLES == 1: toggle debounced_o on this edge; stay STABLE.
  - otherwise: go to PENDING, counter <= 1.
- State PENDING (busy_o = 1, combinational from state):
  - if s == debounced_o: bounce. Go to STABLE, counter <= 0, glitch count +1. debounced_o unchanged.
  - else if counter == DEBOUNCE_CYCLES-1: debounced_o <= ~debounced_o; go to STABLE; counter <= 0.
  - else: counter <= counter + 1.
- Latency: a clean step on raw_i, set up before edge 0, appears on debounced_o after edge DEBOUNCE_CYCLES+1. With the default of 4, that is 6 clock edges after the change.
- Any excursion of s lasting fewer than DEBOUNCE_CYCLES consecutive samples never reaches debounced_o.
- debounced_o is glitch-free and changes at most once per DEBOUNCE_CYCLES cycles. At most one toggle per qualification.
- A return of s to the old level on the same edge the count would complete cannot occur: the comparison uses s at that edge, and commit requires s != debounced_o.
- Static outputs only; no handshake.

Optional Feature:
- Macro: INPUT_DEBOUNCER_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt_o port and its GLITCH_W-bit register exist.
  - Increments by 1 on each PENDING->STABLE abort.
  - Saturates at 2^GLITCH_W-1; never wraps.
  - Cleared only by reset.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with raw_i=1, RESET_LEVEL=0 -> debounced_o=0, busy_o=0, glitch_cnt_o=0 after release.
- Clean rise: DEBOUNCE_CYCLES=4, raw_i 0->1 before edge 0 and held.
  - busy_o=1 after edges 2-4.
  - debounced_o=1 exactly after edge 5, i.e. 6 edges after the change.
  - busy_o=0 after edge 5.
- Bounce rejection: raw_i pulses 1 for 2 cycles, 0 for 1, 1 for 3, then back to 0 -> debounced_o stays 0 throughout; glitch_cnt_o=2.
- Clean fall: after a clean rise, raw_i 1->0 held -> debounced_o=0 after the same 6-edge latency. The downstream edge detector sees exactly one rise pulse and one fall pulse.
- Reset mid-qualification: assert reset while busy_o=1 -> debounced_o=RESET_LEVEL, busy_o=0, glitch_cnt_o=0. The pending change is lost.
- Saturation and boundary:
  - GLITCH_W=2: force 5 aborted bounces -> glitch_cnt_o stops at 3.
  - DEBOUNCE_CYCLES=1: raw_i step -> debounced_o follows after 2 edges.
